// File: rtl/wash_panel_ctrl_if.sv
// rtl/wash_panel_ctrl_if.sv - panel button, finish and status signals of wash_panel_ctrl
//
// Groups everything between the panel, time_control and wash_panel_ctrl.
//   btn_power/btn_start/btn_model/btn_water : debounced button levels into the block
//   finish                                  : program complete, from time_control
//   power_light, run_state, current_model,
//   current_water, beep                     : registered status out of the block
// master: the side that drives buttons/finish (panel, bench).
// slave : wash_panel_ctrl itself.
interface wash_panel_ctrl_if;
  logic       btn_power;
  logic       btn_start;
  logic       btn_model;
  logic       btn_water;
  logic       finish;
  logic       power_light;
  logic [1:0] run_state;
  logic [2:0] current_model;
  logic [2:0] current_water;
  logic       beep;

  modport master (
    output btn_power, btn_start, btn_model, btn_water, finish,
    input  power_light, run_state, current_model, current_water, beep
  );

  modport slave (
    input  btn_power, btn_start, btn_model, btn_water, finish,
    output power_light, run_state, current_model, current_water, beep
  );
endinterface

// File: rtl/wash_panel_ctrl.sv
// rtl/wash_panel_ctrl.sv - washer front-panel power/run/pause controller
//
// Turns the four panel buttons into power_light, run_state, current_model and
// current_water for time_control, closes a program with a beep and powers off
// after BEEP_SEC seconds, and powers off after IDLE_SEC idle seconds.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wash_panel_ctrl_if.slave (buttons and finish in, status out)
// Parameters:
//   N        : clk cycles per one-second tick
//   IDLE_SEC : idle seconds before auto power-off
//   BEEP_SEC : beep seconds before auto power-off
module wash_panel_ctrl #(
  parameter int N        = 100_000_000,
  parameter int IDLE_SEC = 10,
  parameter int BEEP_SEC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  wash_panel_ctrl_if.slave   bus
);

  localparam int             CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  SEC_LAST = CW'(N - 1);
  localparam logic [6:0]     IDLE_LIM = 7'(IDLE_SEC);
  localparam logic [6:0]     BEEP_LIM = 7'(BEEP_SEC);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Button bit order everywhere: {power, start, model, water}
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q, sync2_q, prev_q;
  logic [3:0]    rise;
  logic          press_power, press_start, press_model, press_water;

  logic [2:0]    state_q, state_d;
  logic [2:0]    model_q, model_d;
  logic [2:0]    water_q, water_d;
  logic [CW-1:0] sec_cnt_q, sec_cnt_d;
  logic [6:0]    secs_q, secs_d;
  logic [6:0]    secs_inc;
  logic          timing_state;
  logic          tick;
  logic          idle_timeout;
  logic          beep_timeout;
  logic          clear_cnt;

  logic          power_light_q, power_light_d;
  logic [1:0]    run_state_q, run_state_d;
  logic          beep_q, beep_d;

  assign btn_raw = {bus.btn_power, bus.btn_start, bus.btn_model, bus.btn_water};

  // sync2_q is the synchronized level, prev_q its value one cycle earlier
  assign rise = sync2_q & ~prev_q;

  // Only the highest-priority press of a cycle survives
  always_comb begin
    press_power = rise[3];
    press_start = rise[2] & ~rise[3];
    press_model = rise[1] & ~(|rise[3:2]);
    press_water = rise[0] & ~(|rise[3:1]);
  end

  // Second tick only advances in the two timed states
  assign timing_state = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign tick         = timing_state && (sec_cnt_q == SEC_LAST);
  assign secs_inc     = (secs_q == 7'h7f) ? secs_q : secs_q + 7'd1;
  assign idle_timeout = (state_q == ST_IDLE) && tick && (secs_inc >= IDLE_LIM);
  assign beep_timeout = (state_q == ST_DONE) && tick && (secs_inc >= BEEP_LIM);

  always_comb begin
    state_d   = state_q;
    model_d   = model_q;
    water_d   = water_q;
    clear_cnt = 1'b0;

    if (press_power) begin
      if (state_q == ST_OFF) begin
        state_d = ST_IDLE;
        model_d = 3'd0;
        water_d = 3'd2;
      end else begin
        state_d = ST_OFF;
      end
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_OFF;
        end
        ST_IDLE: begin
          // Timeout beats a same-cycle start/model/water press
          if (idle_timeout) begin
            state_d = ST_OFF;
          end else if (press_start) begin
            state_d = ST_RUN;
          end else if (press_model) begin
            model_d   = (model_q == 3'd0) ? 3'd5 : model_q - 3'd1;
            clear_cnt = 1'b1;
          end else if (press_water) begin
            water_d   = (water_q == 3'd5) ? 3'd1 : water_q + 3'd1;
            clear_cnt = 1'b1;
          end
        end
        ST_RUN: begin
          // finish is same-domain, used unsynchronized; it beats start
          if (bus.finish) begin
            state_d = ST_DONE;
          end else if (press_start) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (press_start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (beep_timeout) begin
            state_d = ST_OFF;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // Both counters restart on any state change and on accepted IDLE presses
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    secs_d    = secs_q;
    if (clear_cnt || (state_d != state_q) || !timing_state) begin
      sec_cnt_d = '0;
      secs_d    = '0;
    end else if (tick) begin
      sec_cnt_d = '0;
      secs_d    = secs_inc;
    end else begin
      sec_cnt_d = sec_cnt_q + 1'b1;
    end
  end

  // Status outputs are decoded from the next state so they are registered
  always_comb begin
    power_light_d = (state_d != ST_OFF);
    beep_d        = (state_d == ST_DONE);
    case (state_d)
      ST_RUN,
      ST_DONE:  run_state_d = 2'b01;
      ST_PAUSE: run_state_d = 2'b10;
      default:  run_state_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      state_q       <= ST_OFF;
      model_q       <= 3'd0;
      water_q       <= 3'd2;
      sec_cnt_q     <= '0;
      secs_q        <= '0;
      power_light_q <= 1'b0;
      run_state_q   <= 2'b00;
      beep_q        <= 1'b0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      state_q       <= state_d;
      model_q       <= model_d;
      water_q       <= water_d;
      sec_cnt_q     <= sec_cnt_d;
      secs_q        <= secs_d;
      power_light_q <= power_light_d;
      run_state_q   <= run_state_d;
      beep_q        <= beep_d;
    end
  end

  assign bus.power_light   = power_light_q;
  assign bus.run_state     = run_state_q;
  assign bus.current_model = model_q;
  assign bus.current_water = water_q;
  assign bus.beep          = beep_q;

endmodule
